// File: rtl/top_control_pkg.sv
// Shared widths, host-mode encoding, the core-to-DRAM request bundle and the core opcode set
// for the 4-core matrix processor.
package top_control_pkg;

  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 16;
  localparam int N_CORES = 4;

  // Instruction word: [15:12] opcode, [11:0] DRAM address (low ADDR_W bits) or signed immediate
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_ADD   = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    MODE_IDLE,
    MODE_ILOAD,
    MODE_DLOAD,
    MODE_READ,
    MODE_RUN
  } mode_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
  } dram_req_t;

  function automatic mode_e decode_mode(input logic s2, input logic s3, input logic s4,
                                        input logic s);
    if (s2) return MODE_ILOAD;
    if (s3) return MODE_DLOAD;
    if (s4) return MODE_READ;
    if (s)  return MODE_RUN;
    return MODE_IDLE;
  endfunction

endpackage

// File: rtl/dram_arbiter.sv
// Fixed-priority 4:1 DRAM arbiter (core 1 highest) with read-valid routed back to the
// granted reader one cycle after its grant.
module dram_arbiter
  import top_control_pkg::*;
(
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        run,
  input  dram_req_t [N_CORES-1:0]     req,
  output logic      [N_CORES-1:0]     gnt,
  output logic      [ADDR_W-1:0]      grant_addr,
  output logic      [DATA_W-1:0]      grant_wdata,
  output logic                        grant_we,
  output logic      [N_CORES-1:0]     rvalid
);

  logic               found;
  logic [N_CORES-1:0] rd_gnt;
  logic [N_CORES-1:0] rvalid_p1;

  always_comb begin
    gnt         = '0;
    rd_gnt      = '0;
    grant_addr  = '0;
    grant_wdata = '0;
    grant_we    = 1'b0;
    found       = 1'b0;
    for (int k = 0; k < N_CORES; k++) begin
      if (run && !found && (req[k].re || req[k].we)) begin
        gnt[k]      = 1'b1;
        rd_gnt[k]   = req[k].re;
        grant_addr  = req[k].addr;
        grant_wdata = req[k].wdata;
        grant_we    = req[k].we;
        found       = 1'b1;
      end
    end
  end

  // Held while frozen so a read granted just before a freeze is still delivered on resume
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)   rvalid_p1 <= '0;
    else if (run) rvalid_p1 <= rd_gnt;
  end

  assign rvalid = rvalid_p1;

endmodule

// File: rtl/proc_core.sv
// Accumulator core: fetches from its private IRAM (1-cycle sync read) and issues one DRAM
// request at a time, holding it until granted. Everything freezes while run is low.
module proc_core
  import top_control_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              run,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_we,
  output logic              dram_re,
  input  logic              dram_gnt,
  input  logic [DATA_W-1:0] dram_rdata,
  input  logic              dram_rvalid,
  output logic              halt
);

  typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WAIT, S_HALT} state_e;

  state_e                   state, state_nxt;
  logic [3:0]               op;
  logic signed [11:0]       imm;
  logic signed [DATA_W-1:0] acc;
  logic                     is_store, is_mem;

  assign op         = instr[DATA_W-1 -: 4];
  assign imm        = instr[11:0];
  assign is_store   = (op == OP_STORE);
  assign is_mem     = (op == OP_LOAD) || (op == OP_ADD) || is_store;
  assign dram_addr  = instr[ADDR_W-1:0];
  assign dram_wdata = acc;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)   state <= S_FETCH;
    else if (run) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if (op == OP_HALT) state_nxt = S_HALT;
        else if (is_mem)   state_nxt = S_MEM;
        else               state_nxt = S_FETCH;
      end
      S_MEM:   if (dram_gnt) state_nxt = is_store ? S_FETCH : S_WAIT;
      S_WAIT:  if (dram_rvalid) state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    dram_we = 1'b0;
    dram_re = 1'b0;
    halt    = 1'b0;
    case (state)
      S_MEM: begin
        dram_we = is_store;
        dram_re = !is_store;
      end
      S_HALT:  halt = 1'b1;
      default: ;
    endcase
  end

  // Address 0 is reserved, so fetch begins at 1; unknown opcodes behave as NOP
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      pc <= ADDR_W'(1);
    end else if (run) begin
      case (state)
        S_EXEC:  if (op != OP_HALT && !is_mem) pc <= pc + ADDR_W'(1);
        S_MEM:   if (dram_gnt && is_store)     pc <= pc + ADDR_W'(1);
        S_WAIT:  if (dram_rvalid)              pc <= pc + ADDR_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (run) begin
      if (state == S_EXEC && op == OP_ADDI)
        acc <= acc + DATA_W'(imm);
      else if (state == S_WAIT && dram_rvalid)
        acc <= (op == OP_LOAD) ? dram_rdata : acc + dram_rdata;
    end
  end

endmodule

// File: rtl/top_control_quad.sv
// Top-level control for the 4-core matrix processor: host mode decode, IRAM/DRAM muxing,
// DRAM arbitration between cores and host readout.
module top_control_quad
  import top_control_pkg::*;
(
  input  logic               clock,
  input  logic               rst_n,
  input  logic               start,
  input  logic               start_2,
  input  logic               start_3,
  input  logic               start_4,
  input  logic [ADDR_W-1:0]  addr_ext,
  input  logic [DATA_W-1:0]  Data_in_ins,
  input  logic               iram_write_ext_1,
  input  logic               iram_write_ext_2,
  input  logic               iram_write_ext_3,
  input  logic               iram_write_ext_4,
  input  logic               dram_write_ext,
  input  logic [DATA_W-1:0]  Data_in_dram,
  input  logic               read_en_ext,
  output logic [DATA_W-1:0]  dram_in_1,
  output logic [N_CORES-1:0] core_done
);

  mode_e                  mode;
  logic                   run, iload, dload, readout;
  logic [N_CORES-1:0]     iram_we;

  logic [DATA_W-1:0]      iram [N_CORES][2**ADDR_W];
  logic [DATA_W-1:0]      dram [2**ADDR_W];

  logic [ADDR_W-1:0]      core_pc  [N_CORES];
  logic [DATA_W-1:0]      instr_p1 [N_CORES];
  dram_req_t [N_CORES-1:0] core_req;
  logic [N_CORES-1:0]     gnt, rvalid, halt;
  logic [ADDR_W-1:0]      grant_addr;
  logic [DATA_W-1:0]      grant_wdata;
  logic                   grant_we;
  logic [DATA_W-1:0]      core_rdata_p1;

  assign mode    = decode_mode(start_2, start_3, start_4, start);
  assign run     = (mode == MODE_RUN);
  assign iload   = (mode == MODE_ILOAD);
  assign dload   = (mode == MODE_DLOAD);
  assign readout = (mode == MODE_READ);
  assign iram_we = {iram_write_ext_4, iram_write_ext_3, iram_write_ext_2, iram_write_ext_1};

  for (genvar k = 0; k < N_CORES; k++) begin : g_core
    proc_core u_core (
      .clock       (clock),
      .rst_n       (rst_n),
      .run         (run),
      .pc          (core_pc[k]),
      .instr       (instr_p1[k]),
      .dram_addr   (core_req[k].addr),
      .dram_wdata  (core_req[k].wdata),
      .dram_we     (core_req[k].we),
      .dram_re     (core_req[k].re),
      .dram_gnt    (gnt[k]),
      .dram_rdata  (core_rdata_p1),
      .dram_rvalid (rvalid[k]),
      .halt        (halt[k])
    );
  end

  dram_arbiter u_arb (
    .clock       (clock),
    .rst_n       (rst_n),
    .run         (run),
    .req         (core_req),
    .gnt         (gnt),
    .grant_addr  (grant_addr),
    .grant_wdata (grant_wdata),
    .grant_we    (grant_we),
    .rvalid      (rvalid)
  );

  // Instruction fetch only advances in run mode so a frozen core keeps its fetched word
  always_ff @(posedge clock) begin
    for (int k = 0; k < N_CORES; k++) begin
      if (iload && iram_we[k]) iram[k][addr_ext] <= Data_in_ins;
      if (run) instr_p1[k] <= iram[k][core_pc[k]];
    end
  end

  // grant_we can only be high in run mode, so host and core writes never collide
  always_ff @(posedge clock) begin
    if (dload && dram_write_ext) dram[addr_ext]   <= Data_in_dram;
    else if (grant_we)           dram[grant_addr] <= grant_wdata;
    if (run) core_rdata_p1 <= dram[grant_addr];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n)                       dram_in_1 <= '0;
    else if (readout && read_en_ext)  dram_in_1 <= dram[addr_ext];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) core_done <= '0;
    else        core_done <= core_done | halt;
  end

endmodule

// File: tb/tb_top_control_quad.sv
// Scoreboard bench for top_control_quad: host loads, readout, mode priority, arbitration
// order, freeze, end-to-end 4x4 matrix add, and reset mid-run.
module tb_top_control_quad;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, start_2 = 1'b0, start_3 = 1'b0, start_4 = 1'b0;
  logic [8:0]  addr_ext = '0;
  logic [15:0] Data_in_ins = '0, Data_in_dram = '0;
  logic        iram_write_ext_1 = 1'b0, iram_write_ext_2 = 1'b0;
  logic        iram_write_ext_3 = 1'b0, iram_write_ext_4 = 1'b0;
  logic        dram_write_ext = 1'b0, read_en_ext = 1'b0;
  logic [15:0] dram_in_1;
  logic [3:0]  core_done;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        rd_vld_p1;
  logic        watch_gnt = 1'b0;
  int          cyc = 0;
  int          first_gnt[4] = '{-1, -1, -1, -1};
  int          freeze_gnts = 0;
  int          waited = 0;
  logic [15:0] a_val[16], b_val[16];

  always #5 clock = ~clock;

  top_control_quad u_dut (
    .clock            (clock),
    .rst_n            (rst_n),
    .start            (start),
    .start_2          (start_2),
    .start_3          (start_3),
    .start_4          (start_4),
    .addr_ext         (addr_ext),
    .Data_in_ins      (Data_in_ins),
    .iram_write_ext_1 (iram_write_ext_1),
    .iram_write_ext_2 (iram_write_ext_2),
    .iram_write_ext_3 (iram_write_ext_3),
    .iram_write_ext_4 (iram_write_ext_4),
    .dram_write_ext   (dram_write_ext),
    .Data_in_dram     (Data_in_dram),
    .read_en_ext      (read_en_ext),
    .dram_in_1        (dram_in_1),
    .core_done        (core_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // A readout is only expected when start_4 wins priority with read enable high
  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) rd_vld_p1 <= 1'b0;
    else        rd_vld_p1 <= start_4 && !start_2 && !start_3 && read_en_ext;
  end

  always @(negedge clock) begin
    if (rd_vld_p1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL readout: unexpected data %0h with nothing expected", dram_in_1);
      end else begin
        check("readout", {16'h0, dram_in_1}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clock) begin
    if (watch_gnt) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 4; k++)
        if (u_dut.gnt[k] && first_gnt[k] < 0) first_gnt[k] <= cyc;
    end
  end

  function automatic logic [15:0] prog_word(input int k, input int a);
    int j, s;
    if (a == 0)  return 16'h0000;
    if (a == 13) return 16'hF000;
    j = (a - 1) / 3;
    s = (a - 1) % 3;
    if (s == 0) return 16'h1000 | 16'(16 + 4*k + j);
    if (s == 1) return 16'h2000 | 16'(32 + 4*k + j);
    return 16'h3000 | 16'(48 + 4*k + j);
  endfunction

  task automatic clear_inputs();
    start_2 = 0; start_3 = 0; start_4 = 0;
    iram_write_ext_1 = 0; iram_write_ext_2 = 0; iram_write_ext_3 = 0; iram_write_ext_4 = 0;
    dram_write_ext = 0; read_en_ext = 0;
  endtask

  task automatic iram_write(input logic [3:0] en, input int addr, input logic [15:0] d);
    @(negedge clock);
    start_2 = 1;
    {iram_write_ext_4, iram_write_ext_3, iram_write_ext_2, iram_write_ext_1} = en;
    addr_ext = 9'(addr);
    Data_in_ins = d;
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic dram_write(input int addr, input logic [15:0] d);
    @(negedge clock);
    start_3 = 1; dram_write_ext = 1; addr_ext = 9'(addr); Data_in_dram = d;
    @(negedge clock);
    clear_inputs();
  endtask

  task automatic host_read(input int addr, input logic [15:0] exp);
    @(negedge clock);
    start_4 = 1; read_en_ext = 1; addr_ext = 9'(addr);
    exp_q.push_back(exp);
    @(negedge clock);
    clear_inputs();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      a_val[i] = 16'(i * 37 + 5);
      b_val[i] = 16'(1000 - i * 13);
    end
    a_val[15] = 16'hFFF0;
    b_val[15] = 16'h0020;

    repeat (3) @(negedge clock);
    check("reset dram_in_1", {16'h0, dram_in_1}, 32'h0);
    check("reset core_done", {28'h0, core_done}, 32'h0);
    check("reset core1 pc", {23'h0, u_dut.core_pc[0]}, 32'd1);
    @(negedge clock);
    rst_n = 1;

    iram_write(4'b0001, 1, 16'h1111);
    iram_write(4'b0010, 1, 16'h2222);
    iram_write(4'b0100, 1, 16'h3333);
    iram_write(4'b1000, 1, 16'h4444);
    iram_write(4'b0010, 1, 16'd1234);
    iram_write(4'b0010, 1, 16'd1234);
    check("iram1[1] untouched", {16'h0, u_dut.iram[0][1]}, 32'h1111);
    check("iram2[1] loaded", {16'h0, u_dut.iram[1][1]}, 32'd1234);
    check("iram3[1] untouched", {16'h0, u_dut.iram[2][1]}, 32'h3333);
    check("iram4[1] untouched", {16'h0, u_dut.iram[3][1]}, 32'h4444);
    iram_write(4'b1111, 2, 16'h0ABC);
    for (int k = 0; k < 4; k++)
      check($sformatf("iram%0d[2] multi", k + 1), {16'h0, u_dut.iram[k][2]}, 32'h0ABC);

    @(negedge clock);
    start_3 = 1; iram_write_ext_1 = 1; addr_ext = 9'd1; Data_in_ins = 16'hBEEF;
    @(negedge clock);
    clear_inputs();
    check("iram enable outside iload", {16'h0, u_dut.iram[0][1]}, 32'h1111);

    dram_write(5, 16'd77);
    dram_write(6, 16'd0);
    host_read(6, 16'd0);
    host_read(5, 16'd77);

    @(negedge clock);
    start_4 = 1; dram_write_ext = 1; addr_ext = 9'd5; Data_in_dram = 16'd99;
    @(negedge clock);
    clear_inputs();
    check("readout holds", {16'h0, dram_in_1}, 32'd77);

    @(negedge clock);
    start_2 = 1; start_4 = 1; read_en_ext = 1; addr_ext = 9'd6;
    @(negedge clock);
    clear_inputs();
    check("iload beats readout", {16'h0, dram_in_1}, 32'd77);
    host_read(5, 16'd77);

    for (int k = 0; k < 4; k++)
      for (int a = 0; a < 14; a++)
        iram_write(4'(1 << k), a, prog_word(k, a));
    for (int i = 0; i < 16; i++) begin
      dram_write(16 + i, a_val[i]);
      dram_write(32 + i, b_val[i]);
    end

    @(negedge clock);
    start = 1;
    watch_gnt = 1;
    repeat (12) @(negedge clock);
    start_3 = 1;
    repeat (5) begin
      @(negedge clock);
      if (|u_dut.gnt) freeze_gnts++;
    end
    check("no grant while frozen", freeze_gnts, 0);
    start_3 = 0;

    while (core_done !== 4'hF && waited < 3000) begin
      @(negedge clock);
      waited++;
    end
    check("all cores done", {28'h0, core_done}, 32'hF);
    watch_gnt = 0;
    check("core1 granted", {31'h0, first_gnt[0] >= 0}, 32'd1);
    for (int k = 1; k < 4; k++)
      check($sformatf("grant order core%0d", k + 1), first_gnt[k] - first_gnt[0], k);

    @(negedge clock);
    start = 0;
    for (int i = 0; i < 16; i++) host_read(48 + i, a_val[i] + b_val[i]);
    host_read(16, a_val[0]);

    @(negedge clock);
    start = 1;
    @(negedge clock);
    rst_n = 0;
    #1;
    check("mid-run reset dram_in_1", {16'h0, dram_in_1}, 32'h0);
    check("mid-run reset core_done", {28'h0, core_done}, 32'h0);
    @(negedge clock);
    start = 0;
    rst_n = 1;
    check("iram2[13] intact", {16'h0, u_dut.iram[1][13]}, 32'hF000);
    host_read(53, a_val[5] + b_val[5]);

    repeat (3) @(negedge clock);
    check("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
